// File: rtl/fb_sched_pkg.sv
// fb_sched_pkg
//   Shared types and helpers for the framebuffer line scheduler:
//   - sched_state_e   : memory-port FSM states
//   - bursts_per_line : bursts needed to fetch one active line
//   - disp_addr       : start pixel address of a display burst (full
//                       precision; the caller truncates to its bus width)
package fb_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DISP_REQ  = 3'd1,
    DISP_WAIT = 3'd2,
    WR_REQ    = 3'd3,
    WR_WAIT   = 3'd4
  } sched_state_e;

  function automatic int bursts_per_line(input int h_pixels, input int burst_len);
    return h_pixels / burst_len;
  endfunction

  function automatic logic [63:0] disp_addr(input int unsigned base,
                                            input int unsigned line,
                                            input int unsigned h_pixels,
                                            input int unsigned burst_idx,
                                            input int unsigned burst_len);
    return 64'(base) + 64'(line) * 64'(h_pixels) + 64'(burst_idx) * 64'(burst_len);
  endfunction

endpackage

// File: rtl/fb_line_scheduler.sv
// fb_line_scheduler
//   Prefetches the next display line into a ping-pong line buffer as a
//   series of memory bursts, sharing the single framebuffer port with one
//   draw-engine writer. Display reads win arbitration, but once
//   MAX_DISP_RUN display bursts have gone back to back a waiting writer is
//   served next. A line still unfinished when the next line_start arrives
//   raises the sticky underrun flag and is abandoned.
//
// Ports
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   enable_i            allow new line schedules (a line in progress finishes)
//   line_start_i        start-of-hblank pulse, vcount_i valid with it
//   vcount_i            current line number
//   wr_req_i/wr_addr_i  writer burst request (held until grant) and address
//   wr_gnt_o            one-cycle pulse when the writer burst is accepted
//   mem_req_o/we/addr   burst request to memory, stable until mem_ack_i
//   mem_ack_i           memory accepted the request
//   mem_done_i          accepted burst completed
//   lb_bank_o/lb_burst_o line-buffer bank / slot of the in-flight display burst
//   line_ready_o        pulse when every burst of the target line completed
//   underrun_o          sticky underrun flag
module fb_line_scheduler
  import fb_sched_pkg::*;
#(
  parameter int          ACTIVE_H_PIXELS = 1280,
  parameter int          ACTIVE_LINES    = 720,
  parameter int          TOTAL_LINES     = 750,
  parameter int          BURST_LEN       = 64,
  parameter int          MAX_DISP_RUN    = 4,
  parameter int          ADDR_W          = 24,
  parameter int unsigned FB_BASE         = 0
) (
  input  logic                                         clk_i,
  input  logic                                         rst_n_i,
  input  logic                                         enable_i,
  input  logic                                         line_start_i,
  input  logic [$clog2(TOTAL_LINES)-1:0]               vcount_i,
  input  logic                                         wr_req_i,
  input  logic [ADDR_W-1:0]                            wr_addr_i,
  output logic                                         wr_gnt_o,
  output logic                                         mem_req_o,
  output logic                                         mem_we_o,
  output logic [ADDR_W-1:0]                            mem_addr_o,
  input  logic                                         mem_ack_i,
  input  logic                                         mem_done_i,
  output logic                                         lb_bank_o,
  output logic [$clog2(ACTIVE_H_PIXELS/BURST_LEN)-1:0] lb_burst_o,
  output logic                                         line_ready_o,
  output logic                                         underrun_o
);

  localparam int BPL   = bursts_per_line(ACTIVE_H_PIXELS, BURST_LEN);
  localparam int VC_W  = $clog2(TOTAL_LINES);
  localparam int LB_W  = $clog2(BPL);
  localparam int REM_W = $clog2(BPL + 1);
  localparam int RUN_W = $clog2(MAX_DISP_RUN + 1);

  sched_state_e     state;
  logic [REM_W-1:0] remaining;
  logic [LB_W-1:0]  burst_idx;
  logic [VC_W-1:0]  target;
  logic [RUN_W-1:0] run;
  logic             stale;

  logic [VC_W-1:0]  tgt_c;
  logic             sched_c;
  logic             done_live_c;
  logic             done_stale_c;
  logic             in_flight_c;
  logic [REM_W-1:0] rem_eff_c;

  // Line-start decode and completion bookkeeping
  always_comb begin
    tgt_c        = (vcount_i == VC_W'(TOTAL_LINES - 1)) ? '0 : vcount_i + VC_W'(1);
    sched_c      = line_start_i && enable_i && (32'(tgt_c) < ACTIVE_LINES);
    done_live_c  = (state == DISP_WAIT) && mem_done_i && !stale;
    done_stale_c = (state == DISP_WAIT) && mem_done_i && stale;
    rem_eff_c    = done_live_c ? remaining - REM_W'(1) : remaining;
    // A display burst of the current line is still owed a mem_done_i
    in_flight_c  = (state == DISP_REQ) || ((state == DISP_WAIT) && !mem_done_i);
  end

  // Scheduler FSM, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      remaining    <= '0;
      burst_idx    <= '0;
      target       <= '0;
      run          <= '0;
      stale        <= 1'b0;
      wr_gnt_o     <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      lb_bank_o    <= 1'b0;
      lb_burst_o   <= '0;
      line_ready_o <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      wr_gnt_o     <= 1'b0;
      line_ready_o <= 1'b0;

      if (line_start_i && (rem_eff_c != '0)) begin
        underrun_o <= 1'b1;
      end

      // A new schedule overrides any same-cycle completion of the old line
      if (sched_c) begin
        remaining <= REM_W'(BPL);
        burst_idx <= '0;
        target    <= tgt_c;
      end else if (done_live_c) begin
        remaining <= rem_eff_c;
        burst_idx <= burst_idx + LB_W'(1);
      end

      if (done_live_c && (remaining == REM_W'(1))) begin
        line_ready_o <= 1'b1;
      end

      if (sched_c && in_flight_c) begin
        stale <= 1'b1;
      end else if (done_stale_c) begin
        stale <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (remaining == '0) begin
            run <= '0;
          end
          // Hold off one cycle when a schedule lands here so the request
          // is built from the new line's address
          if (!sched_c) begin
            if ((remaining != '0) && (!wr_req_i || (run < RUN_W'(MAX_DISP_RUN)))) begin
              state      <= DISP_REQ;
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_addr_o <= ADDR_W'(disp_addr(FB_BASE, 32'(target),
                                              ACTIVE_H_PIXELS, 32'(burst_idx),
                                              BURST_LEN));
              lb_bank_o  <= target[0];
              lb_burst_o <= burst_idx;
            end else if (wr_req_i) begin
              state      <= WR_REQ;
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b1;
              mem_addr_o <= wr_addr_i;
            end
          end
        end

        DISP_REQ: begin
          if (mem_ack_i) begin
            state      <= DISP_WAIT;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            if (run != RUN_W'(MAX_DISP_RUN)) begin
              run <= run + RUN_W'(1);
            end
          end
        end

        DISP_WAIT: begin
          if (mem_done_i) begin
            state      <= IDLE;
            lb_bank_o  <= 1'b0;
            lb_burst_o <= '0;
          end
        end

        WR_REQ: begin
          if (mem_ack_i) begin
            state      <= WR_WAIT;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            wr_gnt_o   <= 1'b1;
            run        <= '0;
          end
        end

        WR_WAIT: begin
          if (mem_done_i) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
